// File: rtl/latent_readout_stream_pkg.sv
// ---------------------------------------------------------------------------
// latent_readout_stream_pkg
// Shared definitions for the latent readout slice:
//   - default fixed-point widths of the dense-stage data path
//   - BRAM address and wait-counter widths
//   - readout FSM state encoding
// ---------------------------------------------------------------------------
package latent_readout_stream_pkg;

  localparam int DEF_INT_W  = 10;
  localparam int DEF_FRAC_W = 10;

  localparam int ADDR_W = 2;
  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_STREAM  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/latent_readout_stream_fixed_requant_sat.sv
// ---------------------------------------------------------------------------
// fixed_requant_sat
// Combinational requantiser from Q(IN_INT_W.IN_FRAC_W) to
// Q(OUT_INT_W.OUT_FRAC_W): arithmetic shift right (truncate toward -inf),
// saturate to the output range, optionally clamp negatives to zero.
// Reusable by any dense stage that narrows its fixed-point format.
//
// Ports:
//   i_data  in   IN_INT_W+IN_FRAC_W    signed input value
//   o_data  out  OUT_INT_W+OUT_FRAC_W  signed requantised value
//
// Parameters:
//   RELU_EN  when 1, negative results are replaced by zero after saturation
// ---------------------------------------------------------------------------
module fixed_requant_sat #(
  parameter int IN_INT_W   = 10,
  parameter int IN_FRAC_W  = 10,
  parameter int OUT_INT_W  = 10,
  parameter int OUT_FRAC_W = 10,
  parameter bit RELU_EN    = 1'b0
) (
  input  logic signed [IN_INT_W+IN_FRAC_W-1:0]   i_data,
  output logic signed [OUT_INT_W+OUT_FRAC_W-1:0] o_data
);

  localparam int IN_W  = IN_INT_W + IN_FRAC_W;
  localparam int OUT_W = OUT_INT_W + OUT_FRAC_W;
  localparam int SHIFT = IN_FRAC_W - OUT_FRAC_W;

  logic signed [IN_W-1:0]  w_shifted;
  logic [IN_W-OUT_W:0]     w_upper;
  logic signed [OUT_W-1:0] w_sat;

  // The value fits the output format only when every bit from the output
  // sign position upward is a copy of the sign; otherwise clamp to the rail
  // matching the input sign.
  always_comb begin
    w_shifted = i_data >>> SHIFT;
    w_upper   = w_shifted[IN_W-1:OUT_W-1];
    if (!w_shifted[IN_W-1] && (|w_upper)) begin
      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_shifted[IN_W-1] && !(&w_upper)) begin
      w_sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      w_sat = w_shifted[OUT_W-1:0];
    end
    o_data = w_sat;
    if (RELU_EN && w_sat[OUT_W-1]) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/latent_readout_stream.sv
// ---------------------------------------------------------------------------
// latent_readout_stream
// Consumer of the latent-space dense stage. After the dense stage signals
// done, reads NEURON values from its output BRAM, requantises each one with
// saturation, holds them in a small register file and streams them to the
// decoder over a valid/ready interface.
//
// Ports:
//   clk                   in   1      clock
//   reset                 in   1      asynchronous active-high reset
//   dense_done            in   1      level done from the dense stage
//   dense_output_address  out  2      BRAM read address
//   dense_output_enable   out  1      high while the BRAM read port is owned
//   dense_output_data     in   INT_W+FRAC_W signed BRAM read data
//   latent_valid          out  1      output word valid
//   latent_ready          in   1      decoder accepts word
//   latent_data           out  OUT_INT_W+OUT_FRAC_W signed latent value
//   latent_last           out  1      high with the final word
//   done                  out  1      all words accepted; sticky until reset
//
// Build option:
//   LATENT_READOUT_RELU_EN  when defined, negative requantised values are
//                           stored as zero.
// ---------------------------------------------------------------------------
module latent_readout_stream
  import latent_readout_stream_pkg::*;
#(
  parameter int NEURON       = 2,
  parameter int INT_W        = DEF_INT_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int OUT_INT_W    = 10,
  parameter int OUT_FRAC_W   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                dense_done,
  output logic [ADDR_W-1:0]                   dense_output_address,
  output logic                                dense_output_enable,
  input  logic signed [INT_W+FRAC_W-1:0]      dense_output_data,
  output logic                                latent_valid,
  input  logic                                latent_ready,
  output logic signed [OUT_INT_W+OUT_FRAC_W-1:0] latent_data,
  output logic                                latent_last,
  output logic                                done
);

  localparam int OUT_W = OUT_INT_W + OUT_FRAC_W;
  localparam int REGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NEURON - 1);
  localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(READ_LATENCY - 1);

`ifdef LATENT_READOUT_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_rdIdx;
  logic [ADDR_W-1:0]       r_wrIdx;
  logic [WAIT_W-1:0]       r_waitCnt;
  logic                    r_doneD;
  logic                    r_armed;
  logic [ADDR_W-1:0]       r_address;
  logic                    r_enable;
  logic                    r_valid;
  logic signed [OUT_W-1:0] r_data;
  logic                    r_last;
  logic                    r_done;
  logic signed [OUT_W-1:0] r_regs [REGS];

  logic signed [OUT_W-1:0] w_requant;
  logic [ADDR_W-1:0]       w_nextWr;
  logic                    w_start;

  fixed_requant_sat #(
    .IN_INT_W   (INT_W),
    .IN_FRAC_W  (FRAC_W),
    .OUT_INT_W  (OUT_INT_W),
    .OUT_FRAC_W (OUT_FRAC_W),
    .RELU_EN    (RELU_EN)
  ) u_requant (
    .i_data (dense_output_data),
    .o_data (w_requant)
  );

  // r_armed only becomes set once dense_done has been seen low, so a done
  // level that is already high when reset is released cannot start a frame.
  assign w_start  = dense_done && !r_doneD && r_armed;
  assign w_nextWr = r_wrIdx + ADDR_W'(1);

  // Readout FSM: per word ISSUE, READ_LATENCY x WAIT, CAPTURE with the
  // address held constant, then stream the register file to the decoder.
  // The address is loaded on entry to ISSUE so it is already stable in the
  // ISSUE cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rdIdx   <= '0;
      r_wrIdx   <= '0;
      r_waitCnt <= '0;
      r_doneD   <= 1'b0;
      r_armed   <= 1'b0;
      r_address <= '0;
      r_enable  <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_doneD <= dense_done;
      if (!dense_done) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_rdIdx   <= '0;
            r_address <= '0;
            r_enable  <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_address <= r_rdIdx;
          r_waitCnt <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          r_waitCnt <= r_waitCnt + WAIT_W'(1);
          if (r_waitCnt == LAT_LAST) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_regs[r_rdIdx] <= w_requant;
          if (r_rdIdx != LAST_IDX) begin
            r_rdIdx   <= r_rdIdx + ADDR_W'(1);
            r_address <= r_rdIdx + ADDR_W'(1);
            r_state   <= ST_ISSUE;
          end else begin
            // Present word 0 right away; with a single neuron it is the
            // value being captured in this very cycle.
            r_enable <= 1'b0;
            r_wrIdx  <= '0;
            r_valid  <= 1'b1;
            r_data   <= (NEURON == 1) ? w_requant : r_regs[0];
            r_last   <= (NEURON == 1);
            r_state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (latent_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_wrIdx <= w_nextWr;
              r_data  <= r_regs[w_nextWr];
              r_last  <= (w_nextWr == LAST_IDX);
            end
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dense_output_address = r_address;
  assign dense_output_enable  = r_enable;
  assign latent_valid         = r_valid;
  assign latent_data          = r_data;
  assign latent_last          = r_last;
  assign done                 = r_done;

endmodule
